pc_if_id_reg: RTL

PC_IF_ID_REG -- requirements
Module: pc_if_id_reg

---
 rtl/mips_pkg.sv | 14 +
 rtl/if_id_latch.sv | 41 ++++
 rtl/pc_if_id_reg.sv | 88 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: widths, special encodings and the fetch FSM state type.
package mips_pkg;

    localparam int          PC_W      = 12;
    localparam int          INSTR_W   = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam logic [5:0]  OPC_HLT   = 6'h3F;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_id_latch.sv
// IF/ID pipeline latch: flush (load a bubble) beats load, otherwise hold.
module if_id_latch
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] instr_d,
    input  logic [PC_W-1:0]    npc_d,
    output logic [INSTR_W-1:0] instr_q,
    output logic [PC_W-1:0]    npc_q,
    output logic               valid_q
);

    logic [INSTR_W-1:0] instr_reg;
    logic [PC_W-1:0]    npc_reg;
    logic               valid_reg;

    // Latch update: a bubble is a NOP with NPC 0 and valid cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_reg <= NOP_INSTR;
            npc_reg   <= '0;
            valid_reg <= 1'b0;
        end else if (flush) begin
            instr_reg <= NOP_INSTR;
            npc_reg   <= '0;
            valid_reg <= 1'b0;
        end else if (load) begin
            instr_reg <= instr_d;
            npc_reg   <= npc_d;
            valid_reg <= 1'b1;
        end
    end

    assign instr_q = instr_reg;
    assign npc_q   = npc_reg;
    assign valid_q = valid_reg;

endmodule

// File: rtl/pc_if_id_reg.sv
// Fetch stage: PC register, redirect mux, RUN/HALTED FSM and the IF/ID latch.
module pc_if_id_reg
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [PC_W-1:0]    NPC_reg_out,
    input  logic               lw_use_control_signal,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               jump_taken,
    input  logic [PC_W-1:0]    jump_target,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [PC_W-1:0]    PC_reg_out,
    output logic [INSTR_W-1:0] IF_ID_instr,
    output logic [PC_W-1:0]    IF_ID_NPC,
    output logic               IF_ID_valid,
    output logic               halted
);

    logic [PC_W-1:0] pc_reg;
    logic [PC_W-1:0] pc_next;
    fetch_state_t    state_reg;
    fetch_state_t    state_next;
    logic            latch_load;
    logic            latch_flush;

    logic            redirect;
    logic [PC_W-1:0] redirect_target;
    logic            is_hlt;

    // Branch is resolved in EX, so it is older than a jump in ID and wins.
    assign redirect        = branch_taken | jump_taken;
    assign redirect_target = branch_taken ? branch_target : jump_target;
    assign is_hlt          = (instr_in[31:26] == OPC_HLT);

    // Next-state, next-PC and latch controls: redirect > stall > halted/run.
    always_comb begin
        pc_next     = pc_reg;
        state_next  = state_reg;
        latch_load  = 1'b0;
        latch_flush = 1'b0;
        if (redirect) begin
            pc_next     = {redirect_target[PC_W-1:2], 2'b00};
            state_next  = ST_RUN;
            latch_flush = 1'b1;
        end else if (lw_use_control_signal) begin
            // Everything holds.
        end else if (state_reg == ST_HALTED) begin
            latch_flush = 1'b1;
        end else begin
            latch_load = 1'b1;
            if (is_hlt) begin
                // HLT is captured but the PC stops advancing.
                state_next = ST_HALTED;
            end else begin
                pc_next = NPC_reg_out;
            end
        end
    end

    // PC and FSM state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_reg    <= '0;
            state_reg <= ST_RUN;
        end else begin
            pc_reg    <= pc_next;
            state_reg <= state_next;
        end
    end

    if_id_latch u_if_id_latch (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (latch_load),
        .flush   (latch_flush),
        .instr_d (instr_in),
        .npc_d   (NPC_reg_out),
        .instr_q (IF_ID_instr),
        .npc_q   (IF_ID_NPC),
        .valid_q (IF_ID_valid)
    );

    assign PC_reg_out = pc_reg;
    assign halted     = (state_reg == ST_HALTED);

endmodule
